// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register file write port among NUM_REQ requesters.
// One write per transaction: capture, one-cycle wr_en, wait for ack (or timeout), report.
module rf_write_arbiter #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ACK_TIMEOUT = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [NUM_REQ-1:0]               req_done,
  output logic [NUM_REQ-1:0]               req_err,
  output logic                             rf_wr_en,
  output logic [ADDR_WIDTH-1:0]            rf_wr_addr,
  output logic [DATA_WIDTH-1:0]            rf_wr_data,
  input  logic                             rf_wr_ack,
  output logic                             busy,
  output logic [$clog2(NUM_REQ)-1:0]       grant_id
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_WAIT_ACK = 2'd2,
    S_DONE     = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [ID_W-1:0]         ptr_q, ptr_d;
  logic [ID_W-1:0]         grant_q, grant_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    wr_en_q, wr_en_d;
  logic                    busy_q, busy_d;
  logic [NUM_REQ-1:0]      done_q, done_d;
  logic [NUM_REQ-1:0]      err_q, err_d;

  logic                    pick_valid;
  logic [ID_W-1:0]         pick_id;
  logic [NUM_REQ-1:0]      pick_oh;

  // First valid requester at or after the pointer, wrapping around.
  always_comb begin
    logic [ID_W-1:0] idx;
    idx        = '0;
    pick_valid = 1'b0;
    pick_id    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((32'(ptr_q) + k) % NUM_REQ);
      if (!pick_valid && req_valid[idx]) begin
        pick_valid = 1'b1;
        pick_id    = idx;
      end
    end
  end

  assign pick_oh   = NUM_REQ'(1) << pick_id;
  assign req_ready = (rst_n && (state_q == S_IDLE) && pick_valid) ? pick_oh : '0;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_en_d = 1'b0;
    done_d  = '0;
    err_d   = '0;

    unique case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          addr_d  = req_addr[32'(pick_id) * ADDR_WIDTH +: ADDR_WIDTH];
          data_d  = req_data[32'(pick_id) * DATA_WIDTH +: DATA_WIDTH];
          grant_d = pick_id;
          ptr_d   = (32'(pick_id) == NUM_REQ - 1) ? '0 : pick_id + ID_W'(1);
          wr_en_d = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        // Ack has priority over a timeout landing on the same edge.
        if (rf_wr_ack) begin
          done_d[grant_q] = 1'b1;
          state_d         = S_DONE;
        end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          err_d[grant_q] = 1'b1;
          state_d        = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_en_q <= wr_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign rf_wr_en   = wr_en_q;
  assign rf_wr_addr = addr_q;
  assign rf_wr_data = data_q;
  assign busy       = busy_q;
  assign grant_id   = grant_q;
  assign req_done   = done_q;
  assign req_err    = err_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: transaction-level timing model plus directed literal checks.
module tb_rf_write_arbiter;

  localparam int N  = 4;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N*AW-1:0]   req_addr = '0;
  logic [N*DW-1:0]   req_data = '0;
  logic [N-1:0]      req_ready, req_done, req_err;
  logic              rf_wr_en, rf_wr_ack = 1'b0, busy;
  logic [AW-1:0]     rf_wr_addr;
  logic [DW-1:0]     rf_wr_data;
  logic [1:0]        grant_id;

  rf_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(N), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .req_done(req_done), .req_err(req_err),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .rf_wr_ack(rf_wr_ack), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // requester side
  bit            pend[N];
  bit            waiting[N];
  logic [AW-1:0] ra[N];
  logic [DW-1:0] rd[N];
  bit            mode_hold = 0, mode_rand = 0, spur = 0;
  int            ack_mode = 1;   // 0 random delay, 1 ack after one cycle, 2 never

  // transaction model: m_t counts cycles since capture (1 = wr_en cycle)
  bit            m_busy = 0;
  int            m_t = 0, m_gid = 0, m_last_gid = 0, m_ptr = 0, m_dly = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  logic [DW-1:0] exp_regs[32];
  logic [DW-1:0] act_regs[32];

  int g_log[$];
  int w_cyc[$];
  logic [N-1:0] last_ready, last_done, last_err;
  logic         last_wen, last_busy;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_data;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endfunction

  function automatic int pick(int ptr, logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      req_valid[i]           = pend[i];
      req_addr[i*AW +: AW]   = ra[i];
      req_data[i*DW +: DW]   = rd[i];
    end
  endtask

  task automatic new_req(int i);
    pend[i] = 1;
    ra[i]   = AW'($urandom);
    rd[i]   = $urandom;
  endtask

  task automatic chk_zero(string nm);
    chk({nm, "_ready"}, 64'(req_ready), 0);
    chk({nm, "_done"},  64'(req_done),  0);
    chk({nm, "_err"},   64'(req_err),   0);
    chk({nm, "_wen"},   64'(rf_wr_en),  0);
    chk({nm, "_addr"},  64'(rf_wr_addr), 0);
    chk({nm, "_data"},  64'(rf_wr_data), 0);
    chk({nm, "_busy"},  64'(busy),      0);
    chk({nm, "_gid"},   64'(grant_id),  0);
  endtask

  task automatic model_reset();
    m_busy = 0; m_t = 0; m_ptr = 0; m_last_gid = 0; m_gid = 0;
    m_addr = '0; m_data = '0;
    for (int i = 0; i < N; i++) waiting[i] = 0;
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step();
    logic [N-1:0] e_ready, e_done, e_err;
    int  tend, g;
    bit  ok;
    for (int i = 0; i < N; i++) begin
      if (mode_hold && !pend[i] && !waiting[i]) new_req(i);
      else if (mode_rand && !pend[i] && !waiting[i] && $urandom_range(3) == 0) new_req(i);
      else if (mode_rand && pend[i] && $urandom_range(15) == 0) pend[i] = 0;
    end
    drive_reqs();
    ok   = (m_dly >= 1 && m_dly <= TO);
    tend = ok ? 2 + m_dly : 2 + TO;
    rf_wr_ack = (m_busy && m_dly != 0 && m_t == 1 + m_dly) ||
                (spur && !m_busy && $urandom_range(1) == 0);
    #1;
    g       = pick(m_ptr, req_valid);
    e_ready = (!m_busy && g >= 0) ? N'(1) << g : '0;
    e_done  = (m_busy && m_t == tend && ok)  ? N'(1) << m_gid : '0;
    e_err   = (m_busy && m_t == tend && !ok) ? N'(1) << m_gid : '0;
    chk("ready", 64'(req_ready), 64'(e_ready));
    chk("wr_en", 64'(rf_wr_en), 64'(m_busy && m_t == 1));
    chk("done",  64'(req_done), 64'(e_done));
    chk("err",   64'(req_err),  64'(e_err));
    chk("busy",  64'(busy),     64'(m_busy));
    chk("gid",   64'(grant_id), 64'(m_last_gid));
    chk("addr",  64'(rf_wr_addr), 64'(m_addr));
    chk("data",  64'(rf_wr_data), 64'(m_data));
    last_ready = req_ready; last_done = req_done; last_err = req_err;
    last_wen = rf_wr_en; last_busy = busy; last_addr = rf_wr_addr; last_data = rf_wr_data;
    if (rf_wr_en) begin
      act_regs[rf_wr_addr] = rf_wr_data;
      g_log.push_back(int'(grant_id));
      w_cyc.push_back(cyc);
    end
    if (m_busy && m_t == tend && ok) begin
      exp_regs[m_addr] = m_data;
      chk("regfile", 64'(act_regs[m_addr]), 64'(exp_regs[m_addr]));
    end
    // effect of the coming rising edge
    if (m_busy) begin
      if (m_t == tend) begin
        m_busy = 0;
        waiting[m_gid] = 0;
      end else begin
        m_t++;
      end
    end else if (g >= 0) begin
      m_busy = 1; m_t = 1; m_gid = g; m_last_gid = g;
      m_addr = ra[g]; m_data = rd[g];
      m_ptr = (g + 1) % N;
      pend[g] = 0; waiting[g] = 1;
      m_dly = (ack_mode == 1) ? 1 : (ack_mode == 2) ? 0 : $urandom_range(TO + 1);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(string nm);
    int k;
    for (int i = 0; i < N; i++) pend[i] = 0;
    k = 0;
    while ((m_busy || waiting[0] || waiting[1] || waiting[2] || waiting[3]) && k < 40) begin
      step();
      k++;
    end
    if (k >= 40) chk({nm, "_drain_timeout"}, 1, 0);
  endtask

  initial begin
    int k;
    bit done_seen;
    for (int i = 0; i < 32; i++) begin
      exp_regs[i] = '0;
      act_regs[i] = '0;
    end
    for (int i = 0; i < N; i++) begin
      pend[i] = 1; waiting[i] = 0; ra[i] = AW'(i + 1); rd[i] = 32'h1000 + 32'(i);
    end
    // reset with every requester valid
    drive_reqs();
    #1 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 chk_zero("reset");
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // round robin under full load
    g_log.delete(); w_cyc.delete();
    mode_hold = 1; ack_mode = 1;
    step();
    chk("rst_first_ready", 64'(last_ready), 64'h1);
    for (int i = 0; i < 19; i++) step();
    chk("rr_count", 64'(g_log.size() >= 5), 1);
    if (g_log.size() >= 5) begin
      chk("rr_g0", 64'(g_log[0]), 0);
      chk("rr_g1", 64'(g_log[1]), 1);
      chk("rr_g2", 64'(g_log[2]), 2);
      chk("rr_g3", 64'(g_log[3]), 3);
      chk("rr_g4", 64'(g_log[4]), 0);
      for (int i = 1; i < 5; i++) chk("rr_spacing", 64'(w_cyc[i] - w_cyc[i-1]), 4);
    end
    mode_hold = 0;
    drain("rr");

    // single write to register 7
    pend[2] = 1; ra[2] = 5'd7; rd[2] = 32'hDEADBEEF;
    step();
    chk("sw_ready", 64'(last_ready), 64'h4);
    step();
    chk("sw_wen1", 64'(last_wen), 1);
    chk("sw_addr", 64'(last_addr), 64'd7);
    chk("sw_data", 64'(last_data), 64'hDEADBEEF);
    step();
    chk("sw_wen2", 64'(last_wen), 0);
    step();
    chk("sw_done", 64'(last_done), 64'h4);
    chk("sw_reg7", 64'(act_regs[7]), 64'hDEADBEEF);

    // ack pulses while idle are ignored
    spur = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("spur_busy", 64'(last_busy), 0);
      chk("spur_done", 64'(last_done), 0);
    end
    spur = 0;

    // timeout then a normal write
    ack_mode = 2;
    pend[1] = 1; ra[1] = 5'd9; rd[1] = 32'hBAD0BAD0;
    k = 0; done_seen = 0;
    step();
    while (last_err == '0 && k < 30) begin
      step();
      k++;
      if (last_done != '0) done_seen = 1;
    end
    chk("to_err", 64'(last_err), 64'h2);
    chk("to_cycle", 64'(k), 64'd10);
    chk("to_no_done", 64'(done_seen), 0);
    ack_mode = 1;
    pend[3] = 1; ra[3] = 5'd9; rd[3] = 32'h12345678;
    for (int i = 0; i < 4; i++) step();
    chk("after_to_done", 64'(last_done), 64'h8);

    // reset while waiting for an ack
    ack_mode = 2;
    pend[2] = 1; ra[2] = 5'd3; rd[2] = 32'hCAFEF00D;
    k = 0;
    while (!(m_busy && m_t == 3) && k < 20) begin
      step();
      k++;
    end
    chk("mid_reached", 64'(m_busy && m_t == 3), 1);
    #2 rst_n = 1'b0;
    #1 chk_zero("mid_rst");
    model_reset();
    pend[1] = 1; pend[3] = 1;
    drive_reqs();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1 chk_zero("mid_hold");
      cyc++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    ack_mode = 1;
    step();
    chk("mid_ptr0", 64'(last_ready), 64'h2);
    drain("mid");

    // randomized traffic
    mode_rand = 1; ack_mode = 0; spur = 1;
    for (int i = 0; i < 2000; i++) step();
    mode_rand = 0; spur = 0;
    drain("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
